neopixel_transmitter: RTL and testbench
=======================================

# neopixel_transmitter

Serializes 24-bit GRB pixel words into the WS2812 single-wire NeoPixel waveform on the LED data pin. It is the output end of the LED controller. Board inputs enter through the double-flop synchronizers, and pixel words leave through this block. Pixels arrive over a valid/ready stream with a one-deep holding buffer, so consecutive pixels are sent with no gap. Each frame ends with a latch (low) period, followed by a one-cycle `frame_done` pulse.

## Interface
- `T0H`, 18: cycles `neo_out` is high for a 0 bit (0.36 µs at 50 MHz)
- `T1H`, 35: cycles `neo_out` is high for a 1 bit (0.70 µs)
- `T_BIT`, 63: total cycles per bit; requires `T0H < T1H < T_BIT`
- `T_LATCH`, 2500: low cycles after the last pixel of a frame (50 µs)
- `clock`  in  1  system clock; the block uses this single clock only
- `reset`  in  1  synchronous, active-low reset
- `pix_data`  in  24  pixel word {G[7:0], R[7:0], B[7:0]}, sent MSB first
- `pix_valid`  in  1  `pix_data` and `pix_last` are valid
- `pix_last`  in  1  this pixel is the final pixel of the frame
- `pix_ready`  out  1  the holding register can accept a pixel
- `neo_out`  out  1  registered serial output to the LED strip
- `busy`  out  1  a frame is in progress or a pixel is buffered
- `frame_done`  out  1  one-cycle pulse when the latch period completes

## Operation
- Transfer rule: a pixel transfers on a rising edge where `pix_valid && pix_ready`. The pixel word and its `last` flag are written into the holding register.
- `pix_ready` = hold register empty AND no frame-ending pixel pending.
  - Once a pixel with `pix_last=1` has been accepted, `pix_ready` stays 0 until the latch period starts.
- States: IDLE, SEND, WAIT, LATCH.
- IDLE:
  - `neo_out=0`.
  - When the hold register is full, move it into the shift register (bit index 23, cycle count 0) and go to SEND.
- SEND:
  - `neo_out = (cyc < (shift[23] ? T1H : T0H))`.
  - `cyc` counts 0..T_BIT-1.
  - At `cyc==T_BIT-1` with bits remaining: shift left, decrement the bit index, set `cyc=0`.
- End of the 24th bit:
  - If the current pixel is last: go to LATCH.
  - Else if the hold register is full: load the shift register from the hold register and stay in SEND, with no idle cycle.
  - Else: go to WAIT (underrun).
- WAIT:
  - `neo_out=0`.
  - Load and enter SEND on the first cycle the hold register is full.
  - The block does not bound the gap. An upstream gap ≥ `T_LATCH` latches the strip early, and avoiding that is the producer's responsibility.
- LATCH:
  - `neo_out=0` for `T_LATCH` cycles.
  - The hold register may accept the first pixel of the next frame during this period.
  - On completion: `frame_done=1` for one cycle.
    - If the hold register is full, go directly to SEND.
    - Otherwise go to IDLE.
- `busy` = (state ≠ IDLE) OR hold register full.
- Counter widths: `cyc` is $clog2(T_BIT), the bit index is 5 bits, and the latch counter is $clog2(T_LATCH+1).

## Timing
- Reset values:
  - `neo_out=0`, `busy=0`, `frame_done=0`, state=IDLE, hold register empty.
  - `pix_ready=1` from the first cycle `reset` is high.
- Reset mid-operation: on the next edge, all state is discarded, `neo_out=0`, and no `frame_done` is issued.
- Start latency: transfer at edge k (from IDLE) → shift register loaded at edge k+1 → `neo_out` rises at edge k+2.
- Bit period: exactly `T_BIT` cycles, with high time exactly `T0H` or `T1H`.
- Pixel period: 24·`T_BIT` = 1512 cycles, continuous when the hold register is full.
- `frame_done`:
  - Asserted the cycle after the `T_LATCH`-th latch cycle.
  - Frame length from the first rise is N·1512 + `T_LATCH` cycles, then the pulse.
- Simultaneous events:
  - Hold register written and read on the same edge: the read takes the old contents, the write is accepted, and the register stays full.
  - `pix_valid` with `pix_ready=0`: no transfer; the producer must hold its data.

## Structure
- Package `neopixel_pkg`:
  - `pixel_t` (packed struct g, r, b; 8 bits each)
  - `tx_state_t` enum {IDLE, SEND, WAIT, LATCH}
  - Default timing constants
- Sub-module `neopixel_bit_timer`:
  - Owns the `cyc` counter and the high-time compare.
  - Inputs: start, bit value. Outputs: `neo_level`, `bit_end`.
- The hold register uses the team's existing `register` module with enable.

## Test plan
- Single pixel `24'hFF0000`, `pix_last=1`:
  - 8 bits at 35 high / 28 low, then 16 bits at 18 high / 45 low.
  - Then 2500 cycles low, and `frame_done` at 1512+2500 cycles after the first rise.
- Pixel `24'hA5A5A5`: bit sequence 10100101 repeated three times, checked via high widths 35/18.
- Three pixels with `pix_valid` held high:
  - No gap between pixels.
  - `pix_ready` drops once the hold register is full and pulses once per 1512 cycles.
- Underrun, second pixel presented 100 cycles after pixel 1 ends:
  - `neo_out=0` during WAIT.
  - Pixel 2 begins 2 cycles after acceptance.
  - `frame_done` follows pixel 2.
- Pixel offered during LATCH:
  - Accepted.
  - `neo_out` rises the cycle after `frame_done`.
- `reset` driven low during bit 10 of a pixel:
  - Next edge: `neo_out=0`, `busy=0`, `pix_ready=1`.
  - No `frame_done` pulse follows.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared types and default WS2812 timing for the NeoPixel output path.
package neopixel_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    LATCH
  } tx_state_t;

  localparam int unsigned T0H_DEF     = 18;
  localparam int unsigned T1H_DEF     = 35;
  localparam int unsigned T_BIT_DEF   = 63;
  localparam int unsigned T_LATCH_DEF = 2500;
  localparam int unsigned PIX_BITS    = 24;

endpackage

// File: rtl/neopixel_transmitter_if.sv
// Pixel stream (valid/ready) between the frame producer and the transmitter.
interface neopixel_transmitter_if;
  import neopixel_pkg::*;

  pixel_t pix_data;
  logic   pix_valid;
  logic   pix_last;
  logic   pix_ready;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);

endinterface

// File: rtl/neopixel_bit_timer.sv
// Per-bit cycle counter and high-time compare for one WS2812 bit slot.
module neopixel_bit_timer #(
  parameter int unsigned T0H   = 18,
  parameter int unsigned T1H   = 35,
  parameter int unsigned T_BIT = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic neo_level,
  output logic bit_end
);

  localparam int unsigned CYC_W = $clog2(T_BIT);
  localparam logic [CYC_W-1:0] T0H_C = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] T1H_C = CYC_W'(T1H);
  localparam logic [CYC_W-1:0] END_C = CYC_W'(T_BIT - 1);

  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_d;

  assign bit_end   = run && (cyc_q == END_C);
  assign neo_level = run && (cyc_q < (bit_val ? T1H_C : T0H_C));

  // Counter rests at zero outside a bit so every new bit starts aligned.
  always_comb begin
    cyc_d = cyc_q + CYC_W'(1);
    if (start || !run || bit_end) cyc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-low reset.
module register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/neopixel_transmitter.sv
// Serializes GRB pixel words into the WS2812 waveform, with a one-deep
// holding register for gapless pixels and a latch period closing each frame.
module neopixel_transmitter
  import neopixel_pkg::*;
#(
  parameter int unsigned T0H     = T0H_DEF,
  parameter int unsigned T1H     = T1H_DEF,
  parameter int unsigned T_BIT   = T_BIT_DEF,
  parameter int unsigned T_LATCH = T_LATCH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  neopixel_transmitter_if.slave        pix,
  output logic                         neo_out,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned LAT_W = $clog2(T_LATCH + 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(T_LATCH);
  localparam logic [4:0]       LAST_IDX = 5'(PIX_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       idx_q, idx_d;
  logic             cur_last_q, cur_last_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             pend_q, pend_d;
  logic             full_q, full_d;
  logic             neo_q, neo_d;
  logic             done_q, done_d;

  logic        ready;
  logic        accept;
  logic        load;
  logic        enter_latch;
  logic [24:0] hold_word;
  logic        neo_level;
  logic        bit_end;

  assign ready         = !full_q && !pend_q;
  assign accept        = pix.pix_valid && ready;
  assign pix.pix_ready = ready;

  register #(.WIDTH(25)) u_hold (
    .clk   (clock),
    .rst_n (reset),
    .en    (accept),
    .d     ({pix.pix_last, pix.pix_data}),
    .q     (hold_word)
  );

  neopixel_bit_timer #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT)) u_timer (
    .clk       (clock),
    .rst_n     (reset),
    .start     (load),
    .run       (state_q == SEND),
    .bit_val   (shift_q[23]),
    .neo_level (neo_level),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    cur_last_d  = cur_last_q;
    lat_d       = '0;
    load        = 1'b0;
    enter_latch = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: load = full_q;
      SEND: begin
        if (bit_end) begin
          if (idx_q != '0) begin
            shift_d = {shift_q[22:0], 1'b0};
            idx_d   = idx_q - 5'd1;
          end else if (cur_last_q) begin
            state_d     = LATCH;
            enter_latch = 1'b1;
          end else if (full_q) begin
            load = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: load = full_q;
      LATCH: begin
        // Counts T_LATCH+1 state cycles: neo_out lags the state by one flop.
        if (lat_q == LAT_END) begin
          done_d  = 1'b1;
          state_d = IDLE;
          load    = full_q;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = SEND;
      shift_d    = hold_word[23:0];
      idx_d      = LAST_IDX;
      cur_last_d = hold_word[24];
    end
  end

  always_comb begin
    full_d = accept || (full_q && !load);
    pend_d = pend_q;
    if (enter_latch)               pend_d = 1'b0;
    if (accept && pix.pix_last)    pend_d = 1'b1;
    neo_d = neo_level;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      cur_last_q <= 1'b0;
      lat_q      <= '0;
      pend_q     <= 1'b0;
      full_q     <= 1'b0;
      neo_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      cur_last_q <= cur_last_d;
      lat_q      <= lat_d;
      pend_q     <= pend_d;
      full_q     <= full_d;
      neo_q      <= neo_d;
      done_q     <= done_d;
    end
  end

  assign neo_out    = neo_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE) || full_q;

endmodule

// File: tb/tb_neopixel_transmitter.sv
// Self-checking bench: timeline model of the WS2812 output plus directed scenarios.
module tb_neopixel_transmitter;

  localparam int T0H     = 18;
  localparam int T1H     = 35;
  localparam int T_BIT   = 63;
  localparam int T_LATCH = 2500;
  localparam int PIX     = 24 * T_BIT;
  localparam int INF     = 32'h7fffffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic neo_out, busy, frame_done;

  neopixel_transmitter_if pix_if ();

  neopixel_transmitter #(
    .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_LATCH(T_LATCH)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .pix        (pix_if),
    .neo_out    (neo_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int t = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Model: each accepted pixel gets an absolute start cycle on the wire.
  typedef struct {
    int          start;
    logic [23:0] data;
  } sched_t;

  sched_t sq[$];
  int     exp_done[$];
  int     avail = 0, hold_load = 0, pend_until = 0, busy_from = 0, busy_until = 0;
  bit     frame_open = 0;
  bit     m_ready = 1;
  int     acc_cnt = 0, acc_t = 0;
  int     rise_t[$], width[$], done_t[$];
  int     hi = 0;
  logic   prev_neo = 1'b0;

  function automatic int exp_neo_at(input int s, input logic [23:0] d, input int now);
    int off, b, c;
    logic [23:0] dd;
    dd  = d;
    off = now - s;
    b   = off / T_BIT;
    c   = off % T_BIT;
    return (c < (dd[23-b] ? T1H : T0H)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int s, e_neo, e_done;
    bit hold_full, e_busy;
    t++;
    if (!rst_n) begin
      sq.delete();
      exp_done.delete();
      avail = 0; hold_load = 0; pend_until = 0;
      busy_from = 0; busy_until = 0; frame_open = 0;
    end else if (pix_if.pix_valid && m_ready) begin
      s = (avail > t + 2) ? avail : t + 2;
      sq.push_back('{s, pix_if.pix_data});
      hold_load = s - 1;
      if (!frame_open) begin
        busy_from  = s - 1;
        busy_until = INF;
        frame_open = 1;
      end
      avail = s + PIX;
      if (pix_if.pix_last) begin
        pend_until = s + PIX - 1;
        exp_done.push_back(s + PIX + T_LATCH);
        busy_until = s + PIX + T_LATCH;
        avail      = s + PIX + T_LATCH + 1;
        frame_open = 0;
      end
      acc_cnt++;
      acc_t = t;
    end
    hold_full = (t < hold_load);
    m_ready   = !hold_full && (t >= pend_until);
    e_busy    = hold_full || (t >= busy_from && t < busy_until);
    e_done    = 0;
    if (exp_done.size() > 0 && exp_done[0] == t) begin
      e_done = 1;
      void'(exp_done.pop_front());
    end
    while (sq.size() > 0 && t >= sq[0].start + PIX) void'(sq.pop_front());
    e_neo = (sq.size() > 0 && t >= sq[0].start) ? exp_neo_at(sq[0].start, sq[0].data, t) : 0;

    chk("neo_out", neo_out, e_neo);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    chk("pix_ready", pix_if.pix_ready, m_ready);

    if (neo_out && !prev_neo) rise_t.push_back(t);
    if (neo_out) hi++;
    if (!neo_out && prev_neo) begin
      width.push_back(hi);
      hi = 0;
    end
    if (frame_done) done_t.push_back(t);
    prev_neo = neo_out;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rise_t.delete();
    width.delete();
    done_t.delete();
  endtask

  task automatic present(input logic [23:0] d, input bit last, input bit keep_valid, output int at);
    int c0;
    c0 = acc_cnt;
    at = -1;
    pix_if.pix_data  = d;
    pix_if.pix_last  = last;
    pix_if.pix_valid = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1;
      if (acc_cnt != c0) begin
        at = acc_t;
        break;
      end
    end
    chk("accepted", (at >= 0) ? 1 : 0, 1);
    if (!keep_valid) pix_if.pix_valid = 1'b0;
  endtask

  initial begin
    int a1, a2, a3;
    logic [7:0] pat;
    pix_if.pix_valid = 1'b0;
    pix_if.pix_last  = 1'b0;
    pix_if.pix_data  = '0;
    rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_ready", pix_if.pix_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_neo", neo_out, 0);
    chk("reset_done", frame_done, 0);
    rst_n = 1'b1;
    wait_cyc(1);

    // Single pixel FF0000
    clear_rec();
    present(24'hFF0000, 1'b1, 1'b0, a1);
    wait_cyc(4100);
    chk("ff_rises", rise_t.size(), 24);
    for (int i = 0; i < 24; i++)
      chk("ff_width", (width.size() > i) ? width[i] : -1, (i < 8) ? 35 : 18);
    chk("ff_start", ((rise_t.size() > 0) ? rise_t[0] : -1) - a1, 2);
    chk("ff_done_ofs", ((done_t.size() > 0) ? done_t[0] : -1) - ((rise_t.size() > 0) ? rise_t[0] : 0), 4012);

    // Pixel A5A5A5
    clear_rec();
    pat = 8'hA5;
    present(24'hA5A5A5, 1'b1, 1'b0, a1);
    wait_cyc(4100);
    for (int i = 0; i < 24; i++)
      chk("a5_width", (width.size() > i) ? width[i] : -1, pat[7 - (i % 8)] ? 35 : 18);
    chk("a5_done_cnt", done_t.size(), 1);

    // Three pixels back to back
    clear_rec();
    present(24'h123456, 1'b0, 1'b1, a1);
    present(24'hABCDEF, 1'b0, 1'b1, a2);
    present(24'h0F0F0F, 1'b1, 1'b0, a3);
    chk("b2b_acc2", a2 - a1, 2);
    chk("b2b_acc3", a3 - a2, 1512);
    wait_cyc(6000);
    chk("b2b_gap1", ((rise_t.size() > 24) ? rise_t[24] : -1) - ((rise_t.size() > 0) ? rise_t[0] : 0), 1512);
    chk("b2b_gap2", ((rise_t.size() > 48) ? rise_t[48] : -1) - ((rise_t.size() > 24) ? rise_t[24] : 0), 1512);
    chk("b2b_frame", ((done_t.size() > 0) ? done_t[0] : -1) - ((rise_t.size() > 0) ? rise_t[0] : 0), 7036);

    // Underrun: second pixel 100 cycles after the first ends
    clear_rec();
    present(24'h00FF00, 1'b0, 1'b0, a1);
    wait_cyc(1614);
    present(24'h0000FF, 1'b1, 1'b0, a2);
    chk("ur_acc", a2 - a1, 1615);
    wait_cyc(4100);
    chk("ur_start2", ((rise_t.size() > 24) ? rise_t[24] : -1) - a2, 2);
    chk("ur_done", ((done_t.size() > 0) ? done_t[0] : -1) - ((rise_t.size() > 24) ? rise_t[24] : 0), 4012);

    // Next frame's pixel offered during the latch period
    clear_rec();
    present(24'h5A5A5A, 1'b1, 1'b0, a1);
    wait_cyc(2014);
    present(24'hC3C3C3, 1'b1, 1'b0, a2);
    chk("lat_acc", a2 - a1, 2015);
    wait_cyc(6100);
    chk("lat_rise", ((rise_t.size() > 24) ? rise_t[24] : -1) - ((done_t.size() > 0) ? done_t[0] : 0), 1);
    chk("lat_done_cnt", done_t.size(), 2);

    // Reset during bit 10
    clear_rec();
    present(24'hFFFFFF, 1'b1, 1'b0, a1);
    wait_cyc(2 + 9 * 63 + 20);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("rst_neo", neo_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pix_if.pix_ready, 1);
    rst_n = 1'b1;
    wait_cyc(4100);
    chk("rst_no_done", done_t.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
